// File: rtl/assemblatore_x7_x0_pkg.sv
// Shared definitions for the serial-to-byte assembler feeding the x7_x0 network input.
package assemblatore_x7_x0_pkg;

  localparam int unsigned NBitDefault = 8;

  typedef enum logic [1:0] {
    Attesa   = 2'b00,
    Presenta = 2'b01,
    Rilascio = 2'b10
  } stato_e;

endpackage

// File: rtl/assemblatore_x7_x0_registro_scorrimento.sv
// Shift register and bit counter. Emits the assembled byte, including the bit arriving this
// cycle, together with a one-cycle completion pulse.
module assemblatore_x7_x0_registro_scorrimento
  import assemblatore_x7_x0_pkg::*;
#(
  parameter int unsigned N_BIT     = NBitDefault,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             bit_in,
  input  logic             strobe,
  input  logic             sync_,
  output logic [N_BIT-1:0] byte_out,
  output logic             done
);

  localparam int unsigned CntW = (N_BIT > 1) ? $clog2(N_BIT) : 1;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_BIT-1:0] sr_q, sr_d, shifted;
  logic             last;

  always_comb begin
    if (MSB_FIRST) shifted = {sr_q[N_BIT-2:0], bit_in};
    else           shifted = {bit_in, sr_q[N_BIT-1:1]};
    last     = (cnt_q == CntW'(N_BIT - 1));
    done     = strobe & sync_ & last;
    byte_out = shifted;
  end

  // A low sync_ wins over a coincident strobe: that bit is discarded.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (!sync_) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (strobe) begin
      sr_d  = shifted;
      cnt_d = last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/assemblatore_x7_x0.sv
// Serial byte assembler with holding register, four-phase dav_/rfd handshake and sticky overrun.
module assemblatore_x7_x0
  import assemblatore_x7_x0_pkg::*;
#(
  parameter int unsigned N_BIT     = NBitDefault,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             bit_in,
  input  logic             strobe,
  input  logic             sync_,
  input  logic             rfd,
  output logic [N_BIT-1:0] x7_x0,
  output logic             dav_,
  output logic             overrun
);

  stato_e           state_q, state_d;
  logic [N_BIT-1:0] holding_q, holding_d;
  logic [N_BIT-1:0] x7_x0_q, x7_x0_d;
  logic             full_q, full_d;
  logic             overrun_q, overrun_d;
  logic [N_BIT-1:0] byte_new;
  logic             done;
  logic             release_hold;

  assemblatore_x7_x0_registro_scorrimento #(
    .N_BIT    (N_BIT),
    .MSB_FIRST(MSB_FIRST)
  ) u_registro_scorrimento (
    .clock   (clock),
    .reset_  (reset_),
    .bit_in  (bit_in),
    .strobe  (strobe),
    .sync_   (sync_),
    .byte_out(byte_new),
    .done    (done)
  );

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= Attesa;
      holding_q <= '0;
      x7_x0_q   <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holding_q <= holding_d;
      x7_x0_q   <= x7_x0_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x7_x0_d      = x7_x0_q;
    release_hold = 1'b0;
    unique case (state_q)
      Attesa: begin
        if (full_q && rfd) begin
          state_d = Presenta;
          x7_x0_d = holding_q;
        end
      end
      Presenta: begin
        if (!rfd) begin
          state_d      = Rilascio;
          release_hold = 1'b1;
        end
      end
      Rilascio: begin
        if (rfd) state_d = Attesa;
      end
      default: state_d = Attesa;
    endcase
  end

  // Holding is freed and refilled on the same edge when a byte completes during release.
  always_comb begin
    holding_d = holding_q;
    full_d    = full_q & ~release_hold;
    overrun_d = overrun_q;
    if (done) begin
      if (!full_q || release_hold) begin
        holding_d = byte_new;
        full_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    dav_    = (state_q != Presenta);
    x7_x0   = x7_x0_q;
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_assemblatore_x7_x0.sv
// Directed bench for assemblatore_x7_x0: vector table plus handshake corner sequences.
module tb_assemblatore_x7_x0;

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic       bit_in = 1'b0;
  logic       strobe = 1'b0;
  logic       sync_ = 1'b1;
  logic       rfd = 1'b1;
  logic [7:0] x7_x0, x7_x0_l;
  logic       dav_, dav_l, overrun, overrun_l;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assemblatore_x7_x0 #(.N_BIT(8), .MSB_FIRST(1'b1)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bit_in (bit_in),
    .strobe (strobe),
    .sync_  (sync_),
    .rfd    (rfd),
    .x7_x0  (x7_x0),
    .dav_   (dav_),
    .overrun(overrun)
  );

  assemblatore_x7_x0 #(.N_BIT(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock  (clock),
    .reset_ (reset_),
    .bit_in (bit_in),
    .strobe (strobe),
    .sync_  (sync_),
    .rfd    (rfd),
    .x7_x0  (x7_x0_l),
    .dav_   (dav_l),
    .overrun(overrun_l)
  );

  typedef struct {
    logic       strobe;
    logic       bit_in;
    logic       sync_;
    logic       rfd;
    logic       exp_dav_;
    logic [7:0] exp_x;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; applies inputs, waits one rising edge, returns at the next falling.
  task automatic cycle(input logic s, input logic b, input logic sy, input logic r);
    strobe = s;
    bit_in = b;
    sync_  = sy;
    rfd    = r;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic r);
    for (int i = 7; i >= 0; i--) cycle(1'b1, v[i], 1'b1, r);
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    strobe = 1'b0;
    sync_  = 1'b1;
    rfd    = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] b1;
    b1 = 8'b1011_0010;
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, b1[7-i], 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0};

    @(negedge clock);
    chk("reset dav_", {7'b0, dav_}, 8'h01);
    chk("reset x7_x0", x7_x0, 8'h00);
    chk("reset overrun", {7'b0, overrun}, 8'h00);
    do_reset();

    // 1: table-driven byte B2 and full handshake
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].strobe, vecs[i].bit_in, vecs[i].sync_, vecs[i].rfd);
      chk($sformatf("t1[%0d] dav_", i), {7'b0, dav_}, {7'b0, vecs[i].exp_dav_});
      chk($sformatf("t1[%0d] x7_x0", i), x7_x0, vecs[i].exp_x);
      chk($sformatf("t1[%0d] overrun", i), {7'b0, overrun}, {7'b0, vecs[i].exp_ovr});
    end

    // 2: overrun while consumer stalls; first byte survives
    send_byte(8'h3C, 1'b0);
    chk("t2 dav_ stalled", {7'b0, dav_}, 8'h01);
    chk("t2 no early ovr", {7'b0, overrun}, 8'h00);
    send_byte(8'hA5, 1'b0);
    chk("t2 overrun", {7'b0, overrun}, 8'h01);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t2 dav_ low", {7'b0, dav_}, 8'h00);
    chk("t2 x7_x0 3C", x7_x0, 8'h3C);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t2 no A5 dav_", {7'b0, dav_}, 8'h01);
    chk("t2 no A5 x7_x0", x7_x0, 8'h3C);

    // 5: async reset mid-PRESENTA with overrun still set
    send_byte(8'h96, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5 dav_ low", {7'b0, dav_}, 8'h00);
    chk("t5 x7_x0 96", x7_x0, 8'h96);
    #2 reset_ = 1'b0;
    #1;
    chk("t5 async dav_", {7'b0, dav_}, 8'h01);
    chk("t5 async x7_x0", x7_x0, 8'h00);
    chk("t5 async ovr", {7'b0, overrun}, 8'h00);
    @(negedge clock);
    reset_ = 1'b1;
    send_byte(8'h4E, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5 after dav_", {7'b0, dav_}, 8'h00);
    chk("t5 after x7_x0", x7_x0, 8'h4E);

    // 3: completion on the same edge rfd=0 is sampled in PRESENTA
    do_reset();
    send_byte(8'h55, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3 first x7_x0", x7_x0, 8'h55);
    for (int i = 7; i >= 1; i--) cycle(1'b1, i[0] ? 1'b1 : 1'b0, 1'b1, 1'b1);
    chk("t3 held dav_", {7'b0, dav_}, 8'h00);
    chk("t3 held x7_x0", x7_x0, 8'h55);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3 rilascio dav_", {7'b0, dav_}, 8'h01);
    chk("t3 no overrun", {7'b0, overrun}, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3 attesa dav_", {7'b0, dav_}, 8'h01);
    chk("t3 attesa x7_x0", x7_x0, 8'h55);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3 second dav_", {7'b0, dav_}, 8'h00);
    chk("t3 second x7_x0", x7_x0, 8'hAA);

    // 4: sync_ realign discards partial byte and a coincident strobe
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    send_byte(8'h81, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4 dav_", {7'b0, dav_}, 8'h00);
    chk("t4 x7_x0", x7_x0, 8'h81);
    chk("t4 overrun", {7'b0, overrun}, 8'h00);

    // 6: LSB-first variant alongside MSB-first
    do_reset();
    send_byte(8'h80, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6 lsb dav_", {7'b0, dav_l}, 8'h00);
    chk("t6 lsb x7_x0", x7_x0_l, 8'h01);
    chk("t6 msb x7_x0", x7_x0, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
